// File: rtl/mem_access_arbiter.sv
// Arbitrates the single MMU port between the I-side refill and D-side miss/write paths.
// Optional bus-state timeout is enabled by defining ARB_TIMEOUT_EN.

`ifndef MMU_WIDTH_BYTE
`define MMU_WIDTH_BYTE 2'b00
`endif
`ifndef MMU_WIDTH_HALF
`define MMU_WIDTH_HALF 2'b01
`endif
`ifndef MMU_WIDTH_WORD
`define MMU_WIDTH_WORD 2'b10
`endif

module mem_access_arbiter #(
  parameter int unsigned STARVE_LIMIT   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic        d_signed,
  input  logic [1:0]  d_width,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        err,
  output logic        busy,
  input  logic        mmu_mem_ready,
  input  logic [31:0] mmu_data_out,
  output logic        mmu_write_enable,
  output logic        mmu_read_enable,
  output logic        mmu_mem_signed_read,
  output logic [1:0]  mmu_mem_data_width,
  output logic [31:0] mmu_address,
  output logic [31:0] mmu_data_in
);

  typedef enum logic [1:0] {StIdle, StIBus, StDBus, StDone} state_e;

  localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);
  localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_LIMIT);

  state_e state_q, state_d;
  logic [StarveW-1:0] starve_q, starve_d;

  logic        i_ack_q, i_ack_d, d_ack_q, d_ack_d, err_q, err_d;
  logic [31:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic        we_q, we_d, re_q, re_d, sgn_q, sgn_d;
  logic [1:0]  width_q, width_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;

  logic in_bus, done_ok, expire, leave_bus, grant_d;

  assign in_bus  = (state_q == StIBus) || (state_q == StDBus);
  assign done_ok = in_bus && mmu_mem_ready;
  // D wins unless I has waited out its starvation budget.
  assign grant_d = d_req && !(i_req && (starve_q == StarveMax));

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ToW-1:0] ToLast = ToW'(TIMEOUT_CYCLES - 1);
  logic [ToW-1:0] to_cnt_q, to_cnt_d;

  always_comb begin
    to_cnt_d = to_cnt_q;
    if (!in_bus)                    to_cnt_d = '0;
    else if (!mmu_mem_ready)        to_cnt_d = to_cnt_q + ToW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) to_cnt_q <= '0;
    else          to_cnt_q <= to_cnt_d;
  end

  // Ready on the terminal cycle wins over the timeout.
  assign expire = in_bus && !mmu_mem_ready && (to_cnt_q == ToLast);
`else
  logic unused_timeout_param;
  assign unused_timeout_param = |TIMEOUT_CYCLES;
  assign expire = 1'b0;
`endif

  assign leave_bus = done_ok || expire;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    unique case (state_q)
      StIdle: begin
        if (grant_d)    state_d = StDBus;
        else if (i_req) state_d = StIBus;
        if (!i_req)       starve_d = '0;
        else if (grant_d) starve_d = (starve_q == StarveMax) ? starve_q : starve_q + StarveW'(1);
        else              starve_d = '0;
      end
      StIBus, StDBus: if (leave_bus) state_d = StDone;
      StDone:         state_d = StIdle;
      default:        state_d = StIdle;
    endcase
  end

  always_comb begin
    i_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    err_d     = 1'b0;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    we_d      = we_q;
    re_d      = re_q;
    sgn_d     = sgn_q;
    width_d   = width_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    unique case (state_q)
      StIdle: begin
        if (grant_d) begin
          we_d    = d_we;
          re_d    = !d_we;
          sgn_d   = d_signed;
          width_d = d_width;
          addr_d  = d_addr;
          wdata_d = d_wdata;
        end else if (i_req) begin
          we_d    = 1'b0;
          re_d    = 1'b1;
          sgn_d   = 1'b0;
          width_d = `MMU_WIDTH_WORD;
          addr_d  = i_addr;
        end
      end
      StIBus, StDBus: begin
        if (leave_bus) begin
          we_d  = 1'b0;
          re_d  = 1'b0;
          err_d = !done_ok;
          if (state_q == StIBus) begin
            i_ack_d   = 1'b1;
            i_rdata_d = done_ok ? mmu_data_out : 32'h0;
          end else begin
            d_ack_d = 1'b1;
            if (re_q) d_rdata_d = done_ok ? mmu_data_out : 32'h0;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_q  <= '0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      err_q     <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      sgn_q     <= 1'b0;
      width_q   <= `MMU_WIDTH_WORD;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      starve_q  <= starve_d;
      i_ack_q   <= i_ack_d;
      d_ack_q   <= d_ack_d;
      err_q     <= err_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      we_q      <= we_d;
      re_q      <= re_d;
      sgn_q     <= sgn_d;
      width_q   <= width_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign i_ack               = i_ack_q;
  assign d_ack               = d_ack_q;
  assign err                 = err_q;
  assign i_rdata             = i_rdata_q;
  assign d_rdata             = d_rdata_q;
  assign busy                = (state_q != StIdle);
  assign mmu_write_enable    = we_q;
  assign mmu_read_enable     = re_q;
  assign mmu_mem_signed_read = sgn_q;
  assign mmu_mem_data_width  = width_q;
  assign mmu_address         = addr_q;
  assign mmu_data_in         = wdata_q;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed, table-driven bench for mem_access_arbiter; define ARB_TIMEOUT_EN to add timeout vectors.

`ifndef MMU_WIDTH_BYTE
`define MMU_WIDTH_BYTE 2'b00
`endif
`ifndef MMU_WIDTH_HALF
`define MMU_WIDTH_HALF 2'b01
`endif
`ifndef MMU_WIDTH_WORD
`define MMU_WIDTH_WORD 2'b10
`endif

module tb_mem_access_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_req, i_ack;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_signed, d_ack;
  logic [1:0]  d_width;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        err, busy;
  logic        mmu_mem_ready;
  logic [31:0] mmu_data_out;
  logic        mmu_write_enable, mmu_read_enable, mmu_mem_signed_read;
  logic [1:0]  mmu_mem_data_width;
  logic [31:0] mmu_address, mmu_data_in;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_arbiter #(
    .STARVE_LIMIT  (4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .i_req              (i_req),
    .i_addr             (i_addr),
    .i_ack              (i_ack),
    .i_rdata            (i_rdata),
    .d_req              (d_req),
    .d_we               (d_we),
    .d_signed           (d_signed),
    .d_width            (d_width),
    .d_addr             (d_addr),
    .d_wdata            (d_wdata),
    .d_ack              (d_ack),
    .d_rdata            (d_rdata),
    .err                (err),
    .busy               (busy),
    .mmu_mem_ready      (mmu_mem_ready),
    .mmu_data_out       (mmu_data_out),
    .mmu_write_enable   (mmu_write_enable),
    .mmu_read_enable    (mmu_read_enable),
    .mmu_mem_signed_read(mmu_mem_signed_read),
    .mmu_mem_data_width (mmu_mem_data_width),
    .mmu_address        (mmu_address),
    .mmu_data_in        (mmu_data_in)
  );

  typedef struct {
    logic        is_d;
    logic        we;
    logic        sgn;
    logic [1:0]  width;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          delay;      // bus cycles before ready is raised
    logic [31:0] mmu_rd;
    int          exp_cyc;    // bus cycles with an enable high
    logic        exp_err;
    logic [31:0] exp_rdata;  // owner's rdata at ack
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int  cyc;
    bit  got;
    @(negedge clk);
    if (v.is_d) begin
      d_req = 1'b1; d_we = v.we; d_signed = v.sgn; d_width = v.width;
      d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      i_req = 1'b1; i_addr = v.addr;
    end
    mmu_mem_ready = 1'b0;
    got = 0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      if (mmu_read_enable || mmu_write_enable) got = 1;
    end
    check($sformatf("v%0d grant", idx), 32'(got), 32'd1);
    check($sformatf("v%0d addr", idx), mmu_address, v.addr);
    check($sformatf("v%0d width", idx), 32'(mmu_mem_data_width),
          32'(v.is_d ? v.width : `MMU_WIDTH_WORD));
    check($sformatf("v%0d signed", idx), 32'(mmu_mem_signed_read), 32'(v.is_d & v.sgn));
    check($sformatf("v%0d we", idx), 32'(mmu_write_enable), 32'(v.is_d & v.we));
    check($sformatf("v%0d re", idx), 32'(mmu_read_enable), 32'(!(v.is_d & v.we)));
    if (v.is_d) check($sformatf("v%0d wdata", idx), mmu_data_in, v.wdata);
    check($sformatf("v%0d busy", idx), 32'(busy), 32'd1);
    cyc = 0;
    got = 0;
    for (int k = 0; k < 300 && !got; k++) begin
      if (i_ack || d_ack) got = 1;
      else begin
        if (mmu_read_enable || mmu_write_enable) cyc++;
        mmu_mem_ready = (cyc > v.delay);
        mmu_data_out  = v.mmu_rd;
        @(negedge clk);
      end
    end
    mmu_mem_ready = 1'b0;
    check($sformatf("v%0d ack seen", idx), 32'(got), 32'd1);
    check($sformatf("v%0d bus cycles", idx), 32'(cyc), 32'(v.exp_cyc));
    check($sformatf("v%0d i_ack", idx), 32'(i_ack), 32'(!v.is_d));
    check($sformatf("v%0d d_ack", idx), 32'(d_ack), 32'(v.is_d));
    check($sformatf("v%0d err", idx), 32'(err), 32'(v.exp_err));
    check($sformatf("v%0d rdata", idx), v.is_d ? d_rdata : i_rdata, v.exp_rdata);
    check($sformatf("v%0d enables off", idx), 32'(mmu_read_enable | mmu_write_enable), 32'd0);
    i_req = 1'b0;
    d_req = 1'b0;
    @(negedge clk);
    check($sformatf("v%0d idle", idx), 32'(busy), 32'd0);
    check($sformatf("v%0d ack pulse", idx), 32'(i_ack | d_ack), 32'd0);
  endtask

  initial begin
    int  gap, n;
    bit  got;
    bit  owners[7];
    bit  exp_own[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    vecs.push_back('{1'b0, 1'b0, 1'b0, `MMU_WIDTH_WORD, 32'h100, 32'h0, 1, 32'h00500093,
                     2, 1'b0, 32'h00500093});
    vecs.push_back('{1'b1, 1'b0, 1'b1, `MMU_WIDTH_HALF, 32'h3002, 32'h0, 0, 32'hFFFF8001,
                     1, 1'b0, 32'hFFFF8001});
    vecs.push_back('{1'b1, 1'b1, 1'b0, `MMU_WIDTH_BYTE, 32'h2003, 32'hAB, 0, 32'h99999999,
                     1, 1'b0, 32'hFFFF8001});
    vecs.push_back('{1'b1, 1'b0, 1'b0, `MMU_WIDTH_WORD, 32'h4000, 32'h0, 3, 32'h12345678,
                     4, 1'b0, 32'h12345678});
    vecs.push_back('{1'b0, 1'b0, 1'b0, `MMU_WIDTH_WORD, 32'h104, 32'h0, 0, 32'hDEADBEEF,
                     1, 1'b0, 32'hDEADBEEF});
    vecs.push_back('{1'b1, 1'b1, 1'b0, `MMU_WIDTH_WORD, 32'h5000, 32'hCAFEF00D, 2, 32'h0,
                     3, 1'b0, 32'h12345678});
`ifdef ARB_TIMEOUT_EN
    vecs.push_back('{1'b0, 1'b0, 1'b0, `MMU_WIDTH_WORD, 32'h108, 32'h0, 1000, 32'h77,
                     8, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, `MMU_WIDTH_WORD, 32'h10C, 32'h0, 7, 32'h55,
                     8, 1'b0, 32'h55});
    vecs.push_back('{1'b1, 1'b0, 1'b0, `MMU_WIDTH_WORD, 32'h6000, 32'h0, 1000, 32'h88,
                     8, 1'b1, 32'h0});
`endif

    reset_n = 1'b0;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_signed = 1'b0; d_width = `MMU_WIDTH_WORD;
    d_addr = '0; d_wdata = '0;
    mmu_mem_ready = 1'b0; mmu_data_out = '0;
    repeat (3) @(negedge clk);
    check("rst busy", 32'(busy), 32'd0);
    check("rst acks", 32'({i_ack, d_ack, err}), 32'd0);
    check("rst enables", 32'({mmu_read_enable, mmu_write_enable, mmu_mem_signed_read}), 32'd0);
    check("rst width", 32'(mmu_mem_data_width), 32'(`MMU_WIDTH_WORD));
    check("rst addr", mmu_address, 32'h0);
    check("rst wdata", mmu_data_in, 32'h0);
    check("rst rdata", i_rdata | d_rdata, 32'h0);
    reset_n = 1'b1;

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Collision: D first, I granted in the IDLE after D's DONE.
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h200;
    d_req = 1'b1; d_we = 1'b0; d_width = `MMU_WIDTH_WORD; d_addr = 32'h300;
    got = 0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      if (mmu_read_enable) got = 1;
    end
    check("coll d first", mmu_address, 32'h300);
    mmu_mem_ready = 1'b1; mmu_data_out = 32'h11;
    @(negedge clk);
    mmu_mem_ready = 1'b0;
    check("coll d_ack", 32'({d_ack, i_ack}), 32'b10);
    check("coll d_rdata", d_rdata, 32'h11);
    d_req = 1'b0;
    gap = 0; got = 0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      gap++;
      if (mmu_read_enable) got = 1;
    end
    check("coll i gap", 32'(gap), 32'd2);
    check("coll i addr", mmu_address, 32'h200);
    mmu_mem_ready = 1'b1; mmu_data_out = 32'h22;
    @(negedge clk);
    mmu_mem_ready = 1'b0;
    check("coll i_ack", 32'({i_ack, d_ack}), 32'b10);
    check("coll i_rdata", i_rdata, 32'h22);
    i_req = 1'b0;
    @(negedge clk);

    // Starvation: continuous D traffic with I pending.
    i_req = 1'b1; d_req = 1'b1; n = 0;
    for (int k = 0; k < 60 && n < 7; k++) begin
      @(negedge clk);
      if (i_ack) i_req = 1'b0;
      if (mmu_read_enable) begin
        owners[n] = (mmu_address == 32'h200);
        n++;
      end
      mmu_mem_ready = mmu_read_enable;
      mmu_data_out  = 32'(k);
    end
    d_req = 1'b0; i_req = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      mmu_mem_ready = mmu_read_enable;
    end
    mmu_mem_ready = 1'b0;
    check("starve grants", 32'(n), 32'd7);
    for (int i = 0; i < 7; i++) check($sformatf("starve owner%0d", i), 32'(owners[i]),
                                      32'(exp_own[i]));
    check("starve idle", 32'(busy), 32'd0);

    // Reset while a D write is on the bus.
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h600; d_wdata = 32'h5A;
    got = 0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      if (mmu_write_enable) got = 1;
    end
    check("rstmid grant", 32'(got), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("rstmid enables", 32'({mmu_write_enable, mmu_read_enable}), 32'd0);
    check("rstmid busy", 32'(busy), 32'd0);
    check("rstmid addr", mmu_address, 32'h0);
    d_req = 1'b0;
    @(negedge clk);
    check("rstmid no ack", 32'({d_ack, i_ack}), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rstmid post busy", 32'(busy), 32'd0);
    check("rstmid post ack", 32'({d_ack, i_ack, mmu_write_enable}), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
